// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-road traffic light sequencer with all-red clearance,
// latched pedestrian requests served as an exclusive walk phase, and a
// remaining-seconds countdown for the 7-segment display path.
`timescale 1ns/1ps
module intersection_ctrl #(
    parameter int CLK_FREQ = 10000000,
    parameter int TICK_DIV = CLK_FREQ,
    parameter int GREEN_T  = 15,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase,
    output logic [5:0] remain
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [5:0] GREEN_L  = 6'(GREEN_T);
    localparam logic [5:0] YELLOW_L = 6'(YELLOW_T);
    localparam logic [5:0] ALLRED_L = 6'(ALLRED_T);
    localparam logic [5:0] WALK_L   = 6'(WALK_T);

    typedef enum logic [2:0] {
        AR_A = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        AR_B = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        WALK = 3'd6
    } state_e;

    // Held as a plain vector so that the illegal encoding 7 is representable.
    logic [2:0]       state_q,    state_d;
    logic [5:0]       remain_q,   remain_d;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             nxt_ew_q,   nxt_ew_d;
    logic             ped_ack_q,  ped_ack_d;
    logic             tick_s;
    logic             expire_s;
    logic             walk_entry_s;

    // State, countdown, divider and pedestrian bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= AR_A;
            remain_q   <= ALLRED_L;
            div_cnt_q  <= DIV_ZERO;
            ped_pend_q <= 1'b0;
            nxt_ew_q   <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            div_cnt_q  <= div_cnt_d;
            ped_pend_q <= ped_pend_d;
            nxt_ew_q   <= nxt_ew_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    // Tick divider, countdown and phase sequencing.
    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        nxt_ew_d     = nxt_ew_q;
        walk_entry_s = 1'b0;
        div_cnt_d    = div_cnt_q;

        tick_s   = en && (div_cnt_q == DIV_LAST);
        // remain==0 is unreachable; treating it like 1 avoids a wrap to 63.
        expire_s = tick_s && (remain_q <= 6'd1);

        if (!en) begin
            div_cnt_d = div_cnt_q;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = DIV_ZERO;
        end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end

        if (tick_s && (remain_q > 6'd1)) begin
            remain_d = remain_q - 6'd1;
        end else begin
            remain_d = remain_q;
        end

        case (state_q)
            AR_A, AR_B: begin
                if (expire_s && ped_pend_q) begin
                    state_d      = WALK;
                    remain_d     = WALK_L;
                    nxt_ew_d     = (state_q == AR_B);
                    walk_entry_s = 1'b1;
                end else if (expire_s) begin
                    state_d  = (state_q == AR_B) ? EW_G : NS_G;
                    remain_d = GREEN_L;
                end else begin
                    state_d = state_q;
                end
            end
            NS_G, EW_G: begin
                if (expire_s) begin
                    state_d  = (state_q == EW_G) ? EW_Y : NS_Y;
                    remain_d = YELLOW_L;
                end else begin
                    state_d = state_q;
                end
            end
            NS_Y, EW_Y: begin
                if (expire_s) begin
                    state_d  = (state_q == EW_Y) ? AR_A : AR_B;
                    remain_d = ALLRED_L;
                end else begin
                    state_d = state_q;
                end
            end
            WALK: begin
                if (expire_s) begin
                    state_d  = nxt_ew_q ? EW_G : NS_G;
                    remain_d = GREEN_L;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = AR_A;
                remain_d = ALLRED_L;
            end
        endcase

        // Entry into WALK clears the request even if ped_req is high that cycle.
        if (walk_entry_s) begin
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = ped_pend_q | ped_req;
        end
        ped_ack_d = walk_entry_s;
    end

    // Lamp decode straight from the state register.
    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        walk      = 1'b0;
        case (state_q)
            NS_G: begin
                ns_red   = 1'b0;
                ns_green = 1'b1;
            end
            NS_Y: begin
                ns_red    = 1'b0;
                ns_yellow = 1'b1;
            end
            EW_G: begin
                ew_red   = 1'b0;
                ew_green = 1'b1;
            end
            EW_Y: begin
                ew_red    = 1'b0;
                ew_yellow = 1'b1;
            end
            WALK: begin
                walk = 1'b1;
            end
            default: begin
                walk = 1'b0;
            end
        endcase
    end

    assign phase   = state_q;
    assign remain  = remain_q;
    assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl with TICK_DIV=4 and default durations.
// The stimulus process pushes the expected phase transitions; a monitor pops
// one entry whenever the DUT changes phase and checks phase, remain, lamps,
// ped_ack and the number of cycles spent in the previous phase.
`timescale 1ns/1ps
module tb_intersection_ctrl;

    localparam int TD   = 4;
    localparam int AR_A = 0;
    localparam int NS_G = 1;
    localparam int NS_Y = 2;
    localparam int AR_B = 3;
    localparam int EW_G = 4;
    localparam int EW_Y = 5;
    localparam int WALK = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       walk;
    logic [2:0] phase;
    logic [5:0] remain;

    intersection_ctrl #(.CLK_FREQ(TD), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req), .ped_ack(ped_ack),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .phase(phase), .remain(remain)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int ph;
        int rem;
        int ack;
        int dur;
    } exp_t;

    exp_t q[$];

    // Expected {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for each legal phase.
    function automatic int lamps_of(int ph);
        case (ph)
            AR_A:    return 7'b100_100_0;
            NS_G:    return 7'b001_100_0;
            NS_Y:    return 7'b010_100_0;
            AR_B:    return 7'b100_100_0;
            EW_G:    return 7'b100_001_0;
            EW_Y:    return 7'b100_010_0;
            WALK:    return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    function automatic int lamps_now();
        return int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk});
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push(input int ph, input int rem, input int ack, input int dur);
        exp_t e;
        e.ph  = ph;
        e.rem = rem;
        e.ack = ack;
        e.dur = dur;
        q.push_back(e);
    endtask

    task automatic tk();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            tk();
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected transitions pending after %0d cycles", q.size(), bound);
            q.delete();
        end
    endtask

    // Monitor: compare each observed phase change against the scoreboard.
    initial begin
        int   last_ph;
        int   last_cyc;
        bit   changed;
        exp_t e;
        last_ph  = 0;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_ph  = int'(phase);
                last_cyc = cyc;
            end else begin
                changed = (int'(phase) != last_ph);
                if (changed) begin
                    if (q.size() == 0) begin
                        chk("unexpected_phase", int'(phase), last_ph);
                    end else begin
                        e = q.pop_front();
                        chk("phase", int'(phase), e.ph);
                        chk("remain_entry", int'(remain), e.rem);
                        chk("lamps", lamps_now(), lamps_of(e.ph));
                        chk("ack_entry", int'(ped_ack), e.ack);
                        if (e.dur >= 0) chk("prev_duration", cyc - last_cyc, e.dur);
                    end
                    last_ph  = int'(phase);
                    last_cyc = cyc;
                end
                if (ped_ack) chk("ack_pulse_first_walk_cycle", int'(changed && phase == 3'(WALK)), 1);
            end
        end
    end

    // Stimulus.
    initial begin
        int n;
        rst_n   = 1'b0;
        en      = 1'b1;
        ped_req = 1'b0;
        repeat (3) tk();
        chk("rst_phase", int'(phase), AR_A);
        chk("rst_remain", int'(remain), 1);
        chk("rst_lamps", lamps_now(), 7'b100_100_0);
        chk("rst_ack", int'(ped_ack), 0);

        // Normal cycle, no pedestrian.
        push(NS_G, 15, 0, 4);  push(NS_Y, 3, 0, 60); push(AR_B, 1, 0, 12);
        push(EW_G, 15, 0, 4);  push(EW_Y, 3, 0, 60); push(AR_A, 1, 0, 12);
        push(NS_G, 15, 0, 4);
        rst_n = 1'b1;
        drain(400);

        // One-cycle request during NS_G, served at AR_B, not again at AR_A.
        push(NS_Y, 3, 0, 60);  push(AR_B, 1, 0, 12); push(WALK, 8, 1, 4);
        push(EW_G, 15, 0, 32); push(EW_Y, 3, 0, 60); push(AR_A, 1, 0, 12);
        push(NS_G, 15, 0, 4);
        ped_req = 1'b1;
        tk();
        ped_req = 1'b0;
        drain(400);

        // Request held high: WALK after every all-red.
        push(NS_Y, 3, 0, 60);  push(AR_B, 1, 0, 12); push(WALK, 8, 1, 4);
        push(EW_G, 15, 0, 32); push(EW_Y, 3, 0, 60); push(AR_A, 1, 0, 12);
        push(WALK, 8, 1, 4);   push(NS_G, 15, 0, 32);
        ped_req = 1'b1;
        drain(400);
        ped_req = 1'b0;

        // en low for 50 cycles at remain=7, div_cnt=2; request still pending.
        push(NS_Y, 3, 0, 110); push(AR_B, 1, 0, 12); push(WALK, 8, 1, 4);
        push(EW_G, 15, 0, 32);
        n = 0;
        while (!(remain == 6'd7 && dut.div_cnt_q == 2'd2) && n < 200) begin
            tk();
            n++;
        end
        chk("hold_sync_found", int'(n < 200), 1);
        en = 1'b0;
        repeat (50) tk();
        chk("hold_phase", int'(phase), NS_G);
        chk("hold_remain", int'(remain), 7);
        chk("hold_lamps", lamps_now(), 7'b001_100_0);
        en = 1'b1;
        tk();
        chk("resume_remain_1cyc", int'(remain), 7);
        tk();
        chk("resume_remain_2cyc", int'(remain), 6);
        drain(400);

        // Illegal encoding recovers to AR_A on the next clock.
        push(AR_A, 1, 0, -1);  push(NS_G, 15, 0, -1); push(NS_Y, 3, 0, 60);
        push(AR_B, 1, 0, 12);  push(EW_G, 15, 0, 4);
        tk();
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        #1;
        chk("illegal_forced", int'(phase), 7);
        tk();
        chk("illegal_recover_phase", int'(phase), AR_A);
        chk("illegal_recover_remain", int'(remain), 1);
        drain(400);

        // Reset during EW_G with a pending request.
        tk();
        ped_req = 1'b1;
        tk();
        ped_req = 1'b0;
        tk();
        chk("pend_latched", int'(dut.ped_pend_q), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ew_green", int'(ew_green), 0);
        chk("arst_ns_red", int'(ns_red), 1);
        chk("arst_ew_red", int'(ew_red), 1);
        chk("arst_remain", int'(remain), 1);
        chk("arst_phase", int'(phase), AR_A);
        chk("arst_pend", int'(dut.ped_pend_q), 0);
        repeat (3) tk();
        push(NS_G, 15, 0, 4);
        rst_n = 1'b1;
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Two-road traffic intersection sequencer that owns the phase timing for a north–south (NS) and an east–west (EW) signal head plus a shared pedestrian crossing. It derives a one-second tick from the system clock and walks a fixed phase cycle with all-red clearance intervals. Pedestrian requests are latched and served as an exclusive walk phase. It drives the lamp outputs directly and exports the remaining-seconds count for the existing 2-digit 7-segment display path.

## Interface
- CLK_FREQ, 10000000: system clock frequency in Hz (informational).
- TICK_DIV, CLK_FREQ: clock cycles per one-second tick; legal range ≥2.
- GREEN_T, 15: green duration in ticks; legal range 1..63.
- YELLOW_T, 3: yellow duration in ticks; legal range 1..63.
- ALLRED_T, 1: all-red clearance duration in ticks; legal range 1..63.
- WALK_T, 8: pedestrian walk duration in ticks; legal range 1..63.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low freezes the tick divider, state and remain.
- ped_req  in  1  pedestrian button, level or pulse; sampled every cycle regardless of en.
- ped_ack  out  1  one-cycle pulse on entry to WALK.
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps, exactly one high.
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps, exactly one high.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding.
- remain  out  6  ticks left in current state, from T down to 1.

## Operation
- States and encoding: AR_A=0, NS_G=1, NS_Y=2, AR_B=3, EW_G=4, EW_Y=5, WALK=6. Any other value is illegal and goes to AR_A with remain=ALLRED_T on the next clock.
- Normal cycle: AR_A→NS_G→NS_Y→AR_B→EW_G→EW_Y→AR_A.
- Pedestrian service: when leaving AR_A or AR_B with ped_pend=1, the block goes to WALK instead of the next green. After WALK it continues to the green that would have followed: NS_G after AR_A, EW_G after AR_B. A 1-bit register, nxt_ew, records the owed green.
- ped_pend is set by ped_req=1 in any cycle and cleared on entry to WALK. If ped_req=1 in the same cycle as WALK entry, the clear wins. A request made while in WALK is latched and served at the next all-red.
- Lamps decode from the state:
  - NS green in NS_G, yellow in NS_Y, red otherwise.
  - EW green in EW_G, yellow in EW_Y, red otherwise.
  - walk=1 only in WALK; both roads are red in WALK, AR_A and AR_B.
- Tick divider: div_cnt counts 0..TICK_DIV-1 while en=1, then wraps to 0. tick = en && div_cnt==TICK_DIV-1.
- Countdown:
  - On tick with remain>1: remain decrements.
  - On tick with remain==1: the state advances and remain loads the new state's duration (GREEN_T, YELLOW_T, ALLRED_T or WALK_T).
  - Each state therefore lasts exactly T ticks.
- en=0 holds div_cnt, remain, state and the lamps. ped_pend still latches. When en returns, counting resumes mid-second from the held div_cnt.

## Timing
- Reset values (asynchronous): state=AR_A, remain=ALLRED_T, div_cnt=0, ped_pend=0, nxt_ew=0, ped_ack=0, walk=0, ns_red=ew_red=1, all yellow and green lamps=0, phase=0.
- First tick after reset occurs TICK_DIV cycles after rst_n deasserts with en=1.
- State, remain and ped_ack are registered. Lamps and phase are combinational from the state register, so they change one cycle after the clock edge where tick and remain==1 are both true. No extra latency.
- ped_ack is high for exactly the first cycle of WALK.
- Minimum ped_req pulse is one clock. A request arriving in the last cycle of an all-red state (the tick cycle) is not served at that all-red; it is served at the next one.
- A mid-operation reset returns to the reset values immediately, with no glitch to green.

## Test plan
- TICK_DIV=4, defaults, en=1, no ped_req:
  - AR_A lasts 4 cycles, NS_G 60, NS_Y 12, AR_B 4, EW_G 60, EW_Y 12, then back to AR_A.
  - Full cycle is 152 cycles; remain reads 15 at NS_G entry.
- One-cycle ped_req during NS_G:
  - Sequence is NS_Y→AR_B→WALK (32 cycles, walk=1, both reds, ped_ack pulse at entry)→EW_G.
  - ped_pend clears at WALK entry.
- ped_req held high continuously:
  - WALK is inserted after every all-red: AR_A→WALK→NS_G…AR_B→WALK→EW_G.
  - ped_ack pulses once per WALK.
- en dropped for 50 cycles mid-NS_G at remain=7, div_cnt=2: all outputs hold. After en rises, the next decrement is 2 cycles later.
- Force phase to 7 via backdoor: the next cycle gives state=AR_A and remain=1.
- rst_n asserted during EW_G: in the same cycle ew_green=0, ns_red=ew_red=1 and remain=ALLRED_T, and ped_pend is cleared.
